// File: rtl/fifo_pkg.sv
// Shared FIFO package: default sizing constants and a constant-evaluable
// clog2 helper, reused by the FIFO family.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  // Ceiling log2; clog2(1) = 0. Usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_W array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address (combinational read)
//   rdata  - read data
module fifo_mem import fifo_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock synchronous FIFO with occupancy count,
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// selectable first-word-fall-through read mode.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   wr, data       - write request and write data
//   rd             - read request (in FWFT mode: acknowledge of data_out)
//   data_out       - read data
//   full, empty    - count == DEPTH / count == 0
//   almost_full    - count >= AFULL_TH
//   almost_empty   - count <= AEMPTY_TH
//   count          - occupancy 0..DEPTH
//   overflow       - one-cycle pulse after a write while full
//   underflow      - one-cycle pulse after a read while empty
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_W-1:0]     data,
  input  logic                  rd,
  output logic [DATA_W-1:0]     data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt_q, cnt_nxt;
  logic              full_q, empty_q, afull_q, aempty_q;
  logic              ovf_q, unf_q;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] rd_data;

  assign wr_en = wr & ~full_q;
  assign rd_en = rd & ~empty_q;

  always_comb begin
    cnt_nxt = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_nxt = cnt_q + CW'(1);
      2'b01:   cnt_nxt = cnt_q - CW'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  // Flags are registered from the next count so every output is a flop
  // output and cannot glitch on decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      cnt_q    <= cnt_nxt;
      full_q   <= (cnt_nxt == CW'(DEPTH));
      empty_q  <= (cnt_nxt == '0);
      afull_q  <= (cnt_nxt >= CW'(AFULL_TH));
      aempty_q <= (cnt_nxt <= CW'(AEMPTY_TH));
      ovf_q    <= wr & full_q;
      unf_q    <= rd & empty_q;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk    (clk),
    .we     (wr_en),
    .waddr  (wr_ptr),
    .wdata  (data),
    .raddr  (rd_ptr),
    .rdata  (rd_data)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; forced to zero so stale or
      // unreset storage never shows while empty.
      assign data_out = empty_q ? '0 : rd_data;
    end else begin : g_reg
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (reset)      dout_q <= '0;
        else if (rd_en) dout_q <= rd_data;
      end
      assign data_out = dout_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, wr, rd, wr1, rd1;
  logic [DW-1:0] data, data1;
  logic [DW-1:0] data_out, data_out1;
  logic          full, empty, afull, aempty, ovf, unf;
  logic          full1, empty1, afull1, aempty1, ovf1, unf1;
  logic [3:0]    count, count1;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(0)) u0 (
    .clk(clk), .reset(reset), .wr(wr), .data(data), .rd(rd),
    .data_out(data_out), .full(full), .empty(empty),
    .almost_full(afull), .almost_empty(aempty), .count(count),
    .overflow(ovf), .underflow(unf)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1)) u1 (
    .clk(clk), .reset(reset), .wr(wr1), .data(data1), .rd(rd1),
    .data_out(data_out1), .full(full1), .empty(empty1),
    .almost_full(afull1), .almost_empty(aempty1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mq[$];     // reference FIFO contents
  logic [DW-1:0] exp_q[$];  // expected read data, popped by the monitor
  int            mcnt = 0;
  logic          rd_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: one read-data comparison per accepted FWFT=0 read.
  always @(negedge clk) begin
    if (rd_chk) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rdata: got %0h expected <none queued>", data_out);
      end else begin
        chk("rdata", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // One cycle on the FWFT=0 instance, with model-based flag checks.
  task automatic op(input logic w, input logic r, input logic [DW-1:0] d);
    int pre; logic wa, ra;
    pre = mcnt;
    wr = w; rd = r; data = d;
    ra = r && (pre > 0);
    wa = w && (pre < DP);
    if (ra) exp_q.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    rd_chk = ra;
    mcnt = pre + int'(wa) - int'(ra);
    chk("count",  32'(count),  32'(mcnt));
    chk("full",   32'(full),   32'(mcnt == DP));
    chk("empty",  32'(empty),  32'(mcnt == 0));
    chk("afull",  32'(afull),  32'(mcnt >= DP - 1));
    chk("aempty", 32'(aempty), 32'(mcnt <= 1));
    chk("ovf",    32'(ovf),    32'(w && pre == DP));
    chk("unf",    32'(unf),    32'(r && pre == 0));
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; data = '0;
    wr1 = 1'b0; rd1 = 1'b0; data1 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_aempty", 32'(aempty), 1);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_unf", 32'(unf), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_dout1", 32'(data_out1), 0);

    // Fill 0x11..0x88, then overflow attempt
    for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, DW'(8'h11 * i));
    chk("full_cnt8", 32'(count), 8);
    op(1'b1, 1'b0, 8'h99);
    chk("ovf_pulse", 32'(ovf), 1);
    op(1'b0, 1'b0, 8'h00);
    chk("ovf_clear", 32'(ovf), 0);

    // Drain, then underflow attempt; data_out holds last word
    for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 8'h00);
    op(1'b0, 1'b1, 8'h00);
    chk("unf_pulse", 32'(unf), 1);
    chk("dout_hold", 32'(data_out), 32'h88);

    // Pointer wrap
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, DW'(8'h20 + i));
    for (int i = 0; i < 5; i++) op(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) op(1'b1, 1'b0, DW'(8'h30 + i));
    for (int i = 0; i < 6; i++) op(1'b0, 1'b1, 8'h00);
    chk("wrap_cnt0", 32'(count), 0);

    // Simultaneous wr/rd at count 3
    for (int i = 0; i < 3; i++) op(1'b1, 1'b0, DW'(8'h60 + i));
    for (int i = 0; i < 20; i++) op(1'b1, 1'b1, DW'(8'h70 + i));
    chk("sim_cnt3", 32'(count), 3);

    // Simultaneous at full: only the read is taken
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, DW'(8'hA0 + i));
    op(1'b1, 1'b1, 8'hEE);
    chk("full_rw_ovf", 32'(ovf), 1);
    chk("full_rw_cnt", 32'(count), 7);

    // Drain, then simultaneous at empty: only the write is taken
    for (int i = 0; i < 7; i++) op(1'b0, 1'b1, 8'h00);
    op(1'b1, 1'b1, 8'h5A);
    chk("empty_rw_unf", 32'(unf), 1);
    chk("empty_rw_cnt", 32'(count), 1);
    op(1'b0, 1'b1, 8'h00);
    op(1'b0, 1'b0, 8'h00);

    // FWFT instance (FWFT=0 instance idles meanwhile)
    rd_chk = 1'b0;
    wr1 = 1'b1; data1 = 8'hA5;
    @(posedge clk); #1;
    wr1 = 1'b0;
    chk("fwft_dout", 32'(data_out1), 32'hA5);
    chk("fwft_empty0", 32'(empty1), 0);
    rd1 = 1'b1;
    @(posedge clk); #1;
    rd1 = 1'b0;
    chk("fwft_dout0", 32'(data_out1), 0);
    chk("fwft_empty1", 32'(empty1), 1);
    wr1 = 1'b1; data1 = 8'h3C;
    @(posedge clk); #1;
    data1 = 8'h4D;
    @(posedge clk); #1;
    wr1 = 1'b0;
    chk("fwft_head1", 32'(data_out1), 32'h3C);
    rd1 = 1'b1;
    @(posedge clk); #1;
    chk("fwft_head2", 32'(data_out1), 32'h4D);
    @(posedge clk); #1;
    rd1 = 1'b0;
    chk("fwft_drain", 32'(data_out1), 0);
    chk("fwft_cnt", 32'(count1), 0);

    // Reset mid-stream with count 5; wr in the reset cycle is ignored
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, DW'(8'hC0 + i));
    op(1'b0, 1'b1, 8'h00);
    op(1'b1, 1'b0, 8'hC5);
    chk("pre_rst_cnt", 32'(count), 5);
    reset = 1'b1; wr = 1'b1; data = 8'hFF;
    @(posedge clk); #1;
    reset = 1'b0; wr = 1'b0;
    rd_chk = 1'b0;
    mq.delete(); mcnt = 0;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_dout", 32'(data_out), 0);
    op(1'b1, 1'b0, 8'h3C);
    op(1'b0, 1'b1, 8'h00);
    op(1'b0, 1'b0, 8'h00);
    chk("mrst_rdata", 32'(data_out), 32'h3C);

    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock synchronous FIFO, the next generation of the team's 8×8 FIFO: configurable data width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, sticky-free overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain and is the standard buffering element for new datapath blocks.

## Interface
- DATA_W, 8, data width in bits
- DEPTH, 8, number of entries; power of two, ≥ 2
- AFULL_TH, DEPTH-1, almost_full asserts when count ≥ AFULL_TH; range 1..DEPTH
- AEMPTY_TH, 1, almost_empty asserts when count ≤ AEMPTY_TH; range 0..DEPTH-1
- FWFT, 0, 0 = registered read (1-cycle latency), 1 = first-word-fall-through
- clk  in  1  rising-edge clock; the block's only clock
- reset  in  1  synchronous, active-high reset
- wr  in  1  write request
- data  in  DATA_W  write data, sampled with wr
- rd  in  1  read request
- data_out  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write attempted while full
- underflow  out  1  one-cycle pulse: read attempted while empty

## Operation
- Accepted write: wr_en = wr & ~full. Accepted read: rd_en = rd & ~empty. full/empty used for gating are the values present in the cycle of the request.
- wr_en: mem[wr_ptr] ← data, wr_ptr ← wr_ptr+1. rd_en: rd_ptr ← rd_ptr+1.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH with no special handling.
- count: +1 on wr_en only, −1 on rd_en only, unchanged on both or neither. count never leaves 0..DEPTH.
- Simultaneous wr & rd: when neither full nor empty, both accepted, count unchanged. When full, read accepted, write rejected, overflow pulses. When empty, write accepted, read rejected, underflow pulses.
- full, empty, almost_full, almost_empty decode the registered count only; glitch-free.
- FWFT=0: on rd_en, data_out ← mem[rd_ptr] at the same edge; otherwise data_out holds.
- FWFT=1: data_out = mem[rd_ptr] while ~empty, 0 while empty; rd acknowledges the presented word.
- overflow/underflow: registered, high for exactly the cycle after the offending request; repeated requests give a pulse per cycle.
- Storage array is not reset; contents after reset are don't-care and never visible on data_out.

## Timing
- Reset (sampled at a rising edge with reset=1): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0. Reset mid-operation discards all stored words; wr/rd in the reset cycle are ignored.
- Write-to-flag latency: flags and count reflect a write one edge after it is accepted.
- FWFT=0 read latency: data_out valid in the cycle after rd_en.
- FWFT=1: a word written into an empty FIFO appears on data_out in the cycle after the write edge (when empty falls).
- Full throughput: one write and one read per cycle sustained indefinitely.

## Structure
- Shared package fifo_pkg: clog2 function and default constants (DATA_W_DEF=8, DEPTH_DEF=8); reused by future FIFO variants.
- One sub-module: fifo_mem — DEPTH×DATA_W array, one synchronous write port, one asynchronous read port addressed by rd_ptr. Pointers, count, flags, error pulses and output register live in sync_fifo_param.

## Test plan
- Reset then write 0x11..0x88 (8 words, DEPTH=8, FWFT=0) → full=1 after 8th edge, count=8, almost_full=1 from count 7; 9th write → overflow pulse, count stays 8.
- Read 8 words from full → data_out 0x11..0x88 in order, each one cycle after its rd; empty=1 after last; extra rd → underflow pulse, data_out holds 0x88.
- Wrap: write 5, read 5, write 6, read 6 → order preserved across pointer wrap, count returns to 0.
- Simultaneous wr/rd at count=3 for 20 cycles → count stays 3, outputs match a reference queue; at full: read only, overflow=1; at empty: write only, underflow=1.
- FWFT=1: write 0xA5 into empty → data_out=0xA5 next cycle with empty=0; rd → data_out=0 and empty=1 next cycle.
- Assert reset with count=5 mid-stream → next cycle count=0, empty=1, data_out=0; subsequent write/read 0x3C returns 0x3C.
